// File: rtl/div_unit.sv
// div_unit: 32-bit restoring radix-2 divider that produces one quotient bit per cycle; result = {remainder, quotient}.
// Define DIV_UNIT_SIGNED_EN to honour signed_div; without it every operation is unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] rem, quo, divisor;
    logic [63:0] result_reg;

    logic        accept;
    logic [31:0] mag_a, mag_b;
    logic [32:0] trial;
    logic [31:0] rem_step, quo_step;
    logic [31:0] rem_fix, quo_fix;

    assign accept = (state == IDLE) && start && !annul;

`ifdef DIV_UNIT_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_q, neg_r;

    assign sign_a = signed_div & opa[31];
    assign sign_b = signed_div & opb[31];
    assign mag_a  = sign_a ? (32'd0 - opa) : opa;
    assign mag_b  = sign_b ? (32'd0 - opb) : opb;

    // Remainder follows the dividend sign; quotient is negative when the signs differ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
        end
    end

    assign quo_fix = neg_q ? (32'd0 - quo_step) : quo_step;
    assign rem_fix = neg_r ? (32'd0 - rem_step) : rem_step;
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div;
    assign mag_a   = opa;
    assign mag_b   = opb;
    assign quo_fix = quo_step;
    assign rem_fix = rem_step;
`endif

    // The next dividend bit is shifted into the partial remainder; keep the difference only if it did not borrow.
    assign trial    = {rem, quo[31]} - {1'b0, divisor};
    assign rem_step = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
    assign quo_step = {quo[30:0], ~trial[32]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = (opb == 32'd0) ? DONE : BUSY;
            end
            BUSY: begin
                if (annul)
                    state_next = IDLE;
                else if (count == 6'd31)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state == BUSY);
    assign ready  = (state == DONE) && !annul;
    assign result = result_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 6'd0;
            rem        <= 32'd0;
            quo        <= 32'd0;
            divisor    <= 32'd0;
            result_reg <= 64'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                count   <= 6'd0;
                rem     <= 32'd0;
                quo     <= mag_a;
                divisor <= mag_b;
                if (opb == 32'd0)
                    result_reg <= {opa, 32'hFFFF_FFFF};
            end else if (state == BUSY) begin
                if (annul) begin
                    count <= 6'd0;
                end else begin
                    rem <= rem_step;
                    quo <= quo_step;
                    if (count == 6'd31) begin
                        result_reg <= {rem_fix, quo_fix};
                        count      <= 6'd0;
                    end else begin
                        count <= count + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed corner cases plus randomized operands against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        annul = 1'b0;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic   use_signed;
`ifdef DIV_UNIT_SIGNED_EN
        use_signed = s;
`else
        use_signed = 1'b0;
`endif
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got result %h with no operation outstanding", result);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result, e);
                end else begin
                    $display("ok result %h", result);
                end
            end
        end
    end

    // poke > 0 re-asserts start with 9/3 during that BUSY cycle, which must be ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int poke);
        logic [63:0] e;
        int n;
        e = ref_div(a, b, s);
        opa = a; opb = b; signed_div = s; start = 1'b1;
        exp_q.push_back(e);
        last_exp = e;
        tick;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (poke > 0 && n == poke) begin
                start = 1'b1; opa = 32'd9; opb = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        check("busy_cycles", 64'(n), (b == 32'd0) ? 64'd0 : 64'd32);
        check("ready_high", 64'(ready), 64'd1);
        tick;
        check("ready_drop", 64'(ready), 64'd0);
        check("result_hold", result, last_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        tick;
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0);
        check("directed_100_7", last_exp, {32'd2, 32'd14});
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'h1234, 32'd0, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

        // Annul at BUSY cycle 10: back to IDLE, no ready, result untouched.
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        check("annul_in_busy", 64'(busy), 64'd1);
        annul = 1'b1;
        tick;
        annul = 1'b0;
        check("annul_idle", 64'(busy), 64'd0);
        check("annul_result", result, last_exp);
        repeat (40) tick;
        run_op(32'd100, 32'd7, 1'b0, 0);

        // Start re-asserted with 9/3 while BUSY.
        run_op(32'd100, 32'd7, 1'b0, 5);

        // start and annul together in IDLE: nothing launches.
        opa = 32'd5; opb = 32'd0; start = 1'b1; annul = 1'b1;
        tick;
        start = 1'b0; annul = 1'b0;
        check("annul_wins_busy", 64'(busy), 64'd0);
        check("annul_wins_ready", 64'(ready), 64'd0);

        // Asynchronous reset at BUSY cycle 5.
        opa = 32'd100; opb = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        last_exp = 64'd0;
        tick;
        rst = 1'b1;
        repeat (40) tick;
        check("rst_no_ready_result", result, 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            int sel;
            a = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - $urandom_range(1, 5);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 32'd0 && sel != 0) b = 32'd1;
            run_op(a, b, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) tick;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
